// File: rtl/pll_clkgen_sup.sv
// ---------------------------------------------------------------------------
// pll_clkgen_sup
//   Generates NUM_CLKS divided clocks and one-cycle clock enables from refclk.
//   Each channel has a divider and a phase preload that can be changed at run
//   time. A resync/settle sequence runs before `locked` is raised. This block
//   sits after the board PLL and drives ADC sampling and UART timing logic.
//
// Ports
//   refclk     in   1         sole clock; all logic runs on the rising edge
//   rst        in   1         asynchronous, active-low reset
//   run        in   1         1 = generate clocks, 0 = idle
//   cfg_valid  in   1         configuration request
//   cfg_ready  out  1         request accepted when cfg_valid & cfg_ready
//   cfg_chan   in   CH_W      channel to program
//   cfg_div    in   DIV_W     new divide value
//   cfg_phase  in   DIV_W     new phase offset (counter preload)
//   cfg_err    out  1         one-cycle pulse: the accepted request was invalid
//   outclk_en  out  NUM_CLKS  one-cycle enable, one pulse per period
//   outclk     out  NUM_CLKS  divided square clock
//   locked     out  1         outputs are stable and valid
// ---------------------------------------------------------------------------
module pll_clkgen_sup #(
  parameter  int NUM_CLKS    = 2,
  parameter  int DIV_W       = 8,
  parameter  int DEFAULT_DIV = 2,
  parameter  int LOCK_CYCLES = 16,
  localparam int CH_W        = (NUM_CLKS > 1) ? $clog2(NUM_CLKS) : 1
) (
  input  logic                refclk,
  input  logic                rst,
  input  logic                run,
  input  logic                cfg_valid,
  output logic                cfg_ready,
  input  logic [CH_W-1:0]     cfg_chan,
  input  logic [DIV_W-1:0]    cfg_div,
  input  logic [DIV_W-1:0]    cfg_phase,
  output logic                cfg_err,
  output logic [NUM_CLKS-1:0] outclk_en,
  output logic [NUM_CLKS-1:0] outclk,
  output logic                locked
);

  localparam int              LCK_W = $clog2(LOCK_CYCLES + 1) + 1;
  localparam logic [CH_W:0]   NCH   = (CH_W + 1)'(NUM_CLKS);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SYNC,
    ST_SETTLE,
    ST_LOCKED
  } state_t;

  state_t             r_state;
  state_t             w_state_next;
  logic [LCK_W-1:0]   r_lock_cnt;

  logic               w_accept;
  logic               w_cfg_ok;
  logic               w_cfg_wr;
  logic               w_cfg_bad;
  logic               w_lock_next;
  logic [NUM_CLKS-1:0] w_en_next;
  logic [NUM_CLKS-1:0] w_clk_next;

  // cfg_ready is a registered output, so the handshake uses its current value.
  assign w_accept  = cfg_valid & cfg_ready;
  assign w_cfg_ok  = ({1'b0, cfg_chan} < NCH) && (cfg_div != '0) && (cfg_phase < cfg_div);
  assign w_cfg_wr  = w_accept & w_cfg_ok;
  assign w_cfg_bad = w_accept & ~w_cfg_ok;

  // -------------------------------------------------------------------------
  // Sequencer: next-state logic. Dropping run always wins.
  // -------------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    if (!run) begin
      w_state_next = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE:   w_state_next = ST_SYNC;
        ST_SYNC:   w_state_next = ST_SETTLE;
        // The settle window spans LOCK_CYCLES+1 cycles, so locked rises
        // LOCK_CYCLES+2 edges after SYNC is entered.
        ST_SETTLE: if (r_lock_cnt == LCK_W'(LOCK_CYCLES)) w_state_next = ST_LOCKED;
        ST_LOCKED: if (w_cfg_wr) w_state_next = ST_SYNC;
        default:   w_state_next = ST_IDLE;
      endcase
    end
  end

  assign w_lock_next = (w_state_next == ST_LOCKED);

  always_ff @(posedge refclk or negedge rst) begin
    if (!rst) begin
      r_state    <= ST_IDLE;
      r_lock_cnt <= '0;
      locked     <= 1'b0;
      cfg_ready  <= 1'b1;
      cfg_err    <= 1'b0;
      outclk_en  <= '0;
      outclk     <= '0;
    end else begin
      r_state <= w_state_next;
      if (r_state == ST_SYNC) begin
        r_lock_cnt <= '0;
      end else if (r_state == ST_SETTLE) begin
        r_lock_cnt <= r_lock_cnt + LCK_W'(1);
      end
      locked    <= w_lock_next;
      cfg_ready <= (w_state_next == ST_IDLE) || (w_state_next == ST_LOCKED);
      cfg_err   <= w_cfg_bad;
      outclk_en <= w_en_next;
      outclk    <= w_clk_next;
    end
  end

  // -------------------------------------------------------------------------
  // Per-channel divider: programmed div/phase plus a free-running counter.
  // -------------------------------------------------------------------------
  for (genvar gi = 0; gi < NUM_CLKS; gi++) begin : g_ch
    logic [DIV_W-1:0] r_div;
    logic [DIV_W-1:0] r_phase;
    logic [DIV_W-1:0] r_cnt;
    logic             w_sel;
    logic             w_wrap;
    logic [DIV_W:0]   w_half;

    assign w_sel  = (cfg_chan == CH_W'(gi));
    assign w_wrap = (r_cnt == (r_div - DIV_W'(1)));
    // High time is ceil(div/2). With div=1 the counter stays at 0, so both
    // outclk and outclk_en remain high.
    assign w_half = ({1'b0, r_div} + (DIV_W + 1)'(1)) >> 1;

    assign w_en_next[gi]  = w_lock_next & w_wrap;
    assign w_clk_next[gi] = w_lock_next & ({1'b0, r_cnt} < w_half);

    always_ff @(posedge refclk or negedge rst) begin
      if (!rst) begin
        r_div   <= DIV_W'(DEFAULT_DIV);
        r_phase <= '0;
        r_cnt   <= '0;
      end else begin
        if (w_cfg_wr && w_sel) begin
          r_div   <= cfg_div;
          r_phase <= cfg_phase;
        end
        // A write in LOCKED enters SYNC on the same edge, so SYNC preloads
        // the newly written phase.
        if (r_state == ST_SYNC) begin
          r_cnt <= r_phase;
        end else if ((r_state == ST_SETTLE) || (r_state == ST_LOCKED)) begin
          r_cnt <= w_wrap ? '0 : (r_cnt + DIV_W'(1));
        end
      end
    end
  end

endmodule

// File: tb/tb_pll_clkgen_sup.sv
// ---------------------------------------------------------------------------
// tb_pll_clkgen_sup
//   Directed and randomized stimulus for pll_clkgen_sup (2 channels, 8-bit
//   dividers, default divide 2, 16 lock cycles). The reference model tracks
//   the edge at which each resync happened. It derives every channel's
//   position from the elapsed edges, computed modulo the divide value.
// ---------------------------------------------------------------------------
module tb_pll_clkgen_sup;

  localparam int NCLK = 2;
  localparam int DW   = 8;
  localparam int LC   = 16;

  logic            refclk;
  logic            rst;
  logic            run;
  logic            cfg_valid;
  logic            cfg_ready;
  logic [0:0]      cfg_chan;
  logic [DW-1:0]   cfg_div;
  logic [DW-1:0]   cfg_phase;
  logic            cfg_err;
  logic [NCLK-1:0] outclk_en;
  logic [NCLK-1:0] outclk;
  logic            locked;

  pll_clkgen_sup #(
    .NUM_CLKS   (NCLK),
    .DIV_W      (DW),
    .DEFAULT_DIV(2),
    .LOCK_CYCLES(LC)
  ) dut (
    .refclk   (refclk),
    .rst      (rst),
    .run      (run),
    .cfg_valid(cfg_valid),
    .cfg_ready(cfg_ready),
    .cfg_chan (cfg_chan),
    .cfg_div  (cfg_div),
    .cfg_phase(cfg_phase),
    .cfg_err  (cfg_err),
    .outclk_en(outclk_en),
    .outclk   (outclk),
    .locked   (locked)
  );

  initial begin
    refclk = 1'b0;
    forever #5 refclk = ~refclk;
  end

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state.
  int e      = 0;   // rising edges counted since the bench started stepping
  bit m_idle = 1'b1;
  int m_s    = 0;   // edge at which the latest resync was entered
  int m_div [NCLK];
  int m_ph  [NCLK];
  bit m_last_acc;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h (edge %0d)", tag, obs, exp, e);
    end
  endtask

  function automatic bit m_locked(input int ee);
    return !m_idle && (ee >= m_s + LC + 2);
  endfunction

  task automatic model_reset();
    m_idle = 1'b1;
    for (int c = 0; c < NCLK; c++) begin
      m_div[c] = 2;
      m_ph[c]  = 0;
    end
  endtask

  // One clock edge: advance the model with the inputs present at the edge,
  // then check every output 1 time unit later.
  task automatic step();
    bit rdy, acc, ok, lk, exp_err;
    logic [NCLK-1:0] exp_en, exp_clk;
    int pos;
    @(posedge refclk);
    e++;
    rdy     = m_idle || m_locked(e - 1);
    acc     = cfg_valid && rdy;
    ok      = (int'(cfg_chan) < NCLK) && (cfg_div != 0) && (cfg_phase < cfg_div);
    exp_err = acc && !ok;
    if (acc && ok) begin
      m_div[cfg_chan] = int'(cfg_div);
      m_ph[cfg_chan]  = int'(cfg_phase);
    end
    if (!run) begin
      m_idle = 1'b1;
    end else if (m_idle) begin
      m_idle = 1'b0;
      m_s    = e;
    end else if (acc && ok) begin
      m_s = e;
    end
    m_last_acc = acc;
    lk = m_locked(e);
    exp_en  = '0;
    exp_clk = '0;
    if (lk) begin
      for (int c = 0; c < NCLK; c++) begin
        pos = (m_ph[c] + (e - m_s - 2)) % m_div[c];
        exp_en[c]  = (pos == m_div[c] - 1);
        exp_clk[c] = (pos < (m_div[c] + 1) / 2);
      end
    end
    #1;
    chk("locked",    32'(locked),    32'(lk));
    chk("cfg_ready", 32'(cfg_ready), 32'(m_idle || lk));
    chk("cfg_err",   32'(cfg_err),   32'(exp_err));
    chk("outclk_en", 32'(outclk_en), 32'(exp_en));
    chk("outclk",    32'(outclk),    32'(exp_clk));
  endtask

  // Holds a request until the handshake completes; bounded.
  task automatic cfg_req(input int ch, input int dv, input int ph);
    bit got;
    got       = 1'b0;
    cfg_chan  = 1'(ch);
    cfg_div   = DW'(dv);
    cfg_phase = DW'(ph);
    cfg_valid = 1'b1;
    for (int i = 0; i < 60; i++) begin
      step();
      if (m_last_acc) begin
        got = 1'b1;
        break;
      end
    end
    cfg_valid = 1'b0;
    $display("cfg chan=%0d div=%0d phase=%0d run=%0b accepted=%0b edge=%0d",
             ch, dv, ph, run, got, e);
    if (!got) begin
      n_checks++;
      n_errors++;
      $error("FAIL cfg_handshake observed=not_accepted expected=accepted (edge %0d)", e);
    end
  endtask

  initial begin
    int dv, ph, gap;
    model_reset();
    run       = 1'b0;
    cfg_valid = 1'b0;
    cfg_chan  = '0;
    cfg_div   = '0;
    cfg_phase = '0;

    // Reset state.
    rst = 1'b1;
    #1 rst = 1'b0;
    #1;
    chk("rst_locked",    32'(locked),    32'd0);
    chk("rst_cfg_ready", 32'(cfg_ready), 32'd1);
    chk("rst_cfg_err",   32'(cfg_err),   32'd0);
    chk("rst_outclk_en", 32'(outclk_en), 32'd0);
    chk("rst_outclk",    32'(outclk),    32'd0);
    @(posedge refclk);
    #2 rst = 1'b1;

    // 1: bring-up, both channels at the default divide of 2.
    run = 1'b1;
    repeat (24) step();

    // 2: reprogram channel 1 to div 5, phase 2.
    cfg_req(1, 5, 2);
    repeat (30) step();

    // 3: invalid requests (zero divide, phase not below divide).
    cfg_req(0, 0, 0);
    repeat (3) step();
    cfg_req(1, 3, 3);
    repeat (12) step();

    // 4: stop, program channel 0 while idle, restart.
    run = 1'b0;
    step();
    cfg_req(0, 4, 0);
    repeat (2) step();
    run = 1'b1;
    repeat (26) step();

    // 5: asynchronous reset during the settle window.
    run = 1'b0;
    step();
    run = 1'b1;
    repeat (8) step();
    #2 rst = 1'b0;
    #1;
    model_reset();
    chk("arst_locked",    32'(locked),    32'd0);
    chk("arst_cfg_ready", 32'(cfg_ready), 32'd1);
    chk("arst_outclk_en", 32'(outclk_en), 32'd0);
    chk("arst_outclk",    32'(outclk),    32'd0);
    @(negedge refclk);
    rst = 1'b1;
    repeat (24) step();

    // 6: divide by 1 on channel 0.
    cfg_req(0, 1, 0);
    repeat (24) step();

    // Randomized requests, with occasional stops between them.
    for (int it = 0; it < 24; it++) begin
      dv  = $urandom_range(0, 7);
      ph  = $urandom_range(0, dv + 1);
      run = ($urandom_range(0, 3) != 0);
      cfg_req($urandom_range(0, 1), dv, ph);
      if (!run) begin
        repeat ($urandom_range(1, 3)) step();
        run = 1'b1;
      end
      gap = $urandom_range(1, 25);
      repeat (gap) step();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
